// File: rtl/spi_cmd_seq.sv
// spi_cmd_seq: APB master that runs single-word SPI transfers on the SPI
// master core. Each command loads TX_0, writes CTRL with GO, waits for the
// transfer to finish, reads RX_0 and returns the masked word on a
// valid/ready response port.
// Build option SPI_CMD_SEQ_IRQ_EN: wait for the core interrupt instead of
// polling CTRL.GO (IE is then set in the CTRL write).
//
// state    | meaning
// INIT_DIV | write DIVIDE after reset
// INIT_SS  | write SS after reset
// IDLE     | cmd_ready high, waiting for a command
// LOAD_TX  | write TX_0 with the command word
// START    | write CTRL with GO
// WAIT     | poll CTRL.GO, or idle the bus until irq
// READ_RX  | read RX_0
// RSP      | hold the response until rsp_ready

module spi_cmd_seq #(
    parameter logic [15:0] DIV_VAL = 16'h0001,
    parameter logic [7:0]  SS_VAL  = 8'h01,
    parameter logic [3:0]  MODE    = 4'b1010,
    parameter logic [15:0] TIMEOUT = 16'hFFFF
) (
    input  logic        PCLK,
    input  logic        PRESETN,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_data,
    input  logic [4:0]  cmd_len,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic [4:0]  m_paddr,
    output logic [31:0] m_pwdata,
    output logic        m_psel,
    output logic        m_penable,
    output logic        m_pwrite,
    input  logic [31:0] m_prdata,
    input  logic        m_pready,
    input  logic        m_pslverr,
    input  logic        irq,
    output logic        busy
);

    localparam logic [2:0] ST_INIT_DIV = 3'd0;
    localparam logic [2:0] ST_INIT_SS  = 3'd1;
    localparam logic [2:0] ST_IDLE     = 3'd2;
    localparam logic [2:0] ST_LOAD_TX  = 3'd3;
    localparam logic [2:0] ST_START    = 3'd4;
    localparam logic [2:0] ST_WAIT     = 3'd5;
    localparam logic [2:0] ST_READ_RX  = 3'd6;
    localparam logic [2:0] ST_RSP      = 3'd7;

    localparam logic [4:0] ADDR_DATA   = 5'h00;
    localparam logic [4:0] ADDR_CTRL   = 5'h10;
    localparam logic [4:0] ADDR_DIVIDE = 5'h14;
    localparam logic [4:0] ADDR_SS     = 5'h18;

`ifdef SPI_CMD_SEQ_IRQ_EN
    localparam logic IE = 1'b1;
`else
    localparam logic IE = 1'b0;
    logic unused_irq;
    assign unused_irq = irq;
`endif

    logic [2:0]  state, state_nxt;
    logic [31:0] data_q;
    logic [4:0]  len_q;
    logic [15:0] tcnt;
    logic        acc_done, in_cmd, to_hit, abort;
    logic        start_acc, acc_write, cap, rsp_load, rsp_err_d;
    logic [4:0]  acc_addr;
    logic [31:0] acc_wdata, rsp_data_d, ctrl_word, mask;
    logic [6:0]  char_len;

    assign cmd_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_RSP);
    assign acc_done  = m_psel & m_penable & m_pready;
    assign in_cmd    = (state >= ST_LOAD_TX) && (state <= ST_READ_RX);
    assign to_hit    = (tcnt >= TIMEOUT);
    // Abort only at an access boundary, so an in-flight access always completes.
    assign abort     = in_cmd && ((acc_done && m_pslverr) || (to_hit && (!m_psel || acc_done)));

    // CTRL word and RX mask derived from the captured bit count (0 means 32).
    always_comb begin
        char_len  = (len_q == 5'd0) ? 7'd32 : {2'b00, len_q};
        mask      = (len_q == 5'd0) ? 32'hFFFF_FFFF : ((32'd1 << len_q) - 32'd1);
        ctrl_word = {18'b0, MODE[3], IE, MODE[2:0], 1'b1, 1'b0, char_len};
    end

    // Next state plus the setup values of the next APB access, if any.
    always_comb begin
        state_nxt  = state;
        start_acc  = 1'b0;
        acc_addr   = 5'd0;
        acc_write  = 1'b0;
        acc_wdata  = 32'd0;
        cap        = 1'b0;
        rsp_load   = 1'b0;
        rsp_data_d = 32'd0;
        rsp_err_d  = 1'b0;
        case (state)
            ST_INIT_DIV: begin
                if (!m_psel) begin
                    start_acc = 1'b1; acc_addr = ADDR_DIVIDE; acc_write = 1'b1;
                    acc_wdata = {16'b0, DIV_VAL};
                end else if (acc_done) begin
                    state_nxt = ST_INIT_SS;
                    start_acc = 1'b1; acc_addr = ADDR_SS; acc_write = 1'b1;
                    acc_wdata = {24'b0, SS_VAL};
                end
            end
            ST_INIT_SS: if (acc_done) state_nxt = ST_IDLE;
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_nxt = ST_LOAD_TX; cap = 1'b1;
                    start_acc = 1'b1; acc_addr = ADDR_DATA; acc_write = 1'b1;
                    acc_wdata = cmd_data;
                end
            end
            ST_LOAD_TX: begin
                if (acc_done) begin
                    state_nxt = ST_START;
                    start_acc = 1'b1; acc_addr = ADDR_CTRL; acc_write = 1'b1;
                    acc_wdata = ctrl_word;
                end
            end
            ST_START: begin
                if (acc_done) begin
                    state_nxt = ST_WAIT;
`ifndef SPI_CMD_SEQ_IRQ_EN
                    start_acc = 1'b1; acc_addr = ADDR_CTRL;
`endif
                end
            end
            ST_WAIT: begin
`ifdef SPI_CMD_SEQ_IRQ_EN
                if (irq) begin
                    state_nxt = ST_READ_RX;
                    start_acc = 1'b1; acc_addr = ADDR_DATA;
                end
`else
                if (acc_done) begin
                    start_acc = 1'b1;
                    if (!m_prdata[8]) begin
                        state_nxt = ST_READ_RX; acc_addr = ADDR_DATA;
                    end else begin
                        acc_addr = ADDR_CTRL;
                    end
                end
`endif
            end
            ST_READ_RX: begin
                if (acc_done) begin
                    state_nxt = ST_RSP; rsp_load = 1'b1;
                    rsp_data_d = m_prdata & mask;
                end
            end
            ST_RSP: if (rsp_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_INIT_DIV;
        endcase
        if (abort) begin
            state_nxt  = ST_RSP;
            start_acc  = 1'b0;
            rsp_load   = 1'b1;
            rsp_data_d = 32'd0;
            rsp_err_d  = 1'b1;
        end
    end

    // State, APB phase sequencing, command capture, timeout and response registers.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state     <= ST_INIT_DIV;
            busy      <= 1'b0;
            m_psel    <= 1'b0;
            m_penable <= 1'b0;
            m_pwrite  <= 1'b0;
            m_paddr   <= 5'd0;
            m_pwdata  <= 32'd0;
            data_q    <= 32'd0;
            len_q     <= 5'd0;
            tcnt      <= 16'd0;
            rsp_data  <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != ST_IDLE);
            if (start_acc) begin
                m_psel    <= 1'b1;
                m_penable <= 1'b0;
                m_paddr   <= acc_addr;
                m_pwrite  <= acc_write;
                m_pwdata  <= acc_wdata;
            end else if (m_psel && !m_penable) begin
                m_penable <= 1'b1;
            end else if (acc_done) begin
                m_psel    <= 1'b0;
                m_penable <= 1'b0;
            end
            if (cap) begin
                data_q <= cmd_data;
                len_q  <= cmd_len;
                tcnt   <= 16'd0;
            end else if (in_cmd && !to_hit) begin
                tcnt <= tcnt + 16'd1;
            end
            if (rsp_load) begin
                rsp_data <= rsp_data_d;
                rsp_err  <= rsp_err_d;
            end
        end
    end

endmodule

// File: tb/tb_spi_cmd_seq.sv
// Bench for spi_cmd_seq: loopback APB SPI core model, directed commands,
// scoreboard queues for APB writes and responses checked by monitors.
module tb_spi_cmd_seq;

    logic        PCLK = 1'b0;
    logic        PRESETN = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_data = 32'd0;
    logic [4:0]  cmd_len = 5'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [4:0]  m_paddr;
    logic [31:0] m_pwdata;
    logic        m_psel, m_penable, m_pwrite;
    logic [31:0] m_prdata;
    logic        m_pready = 1'b0;
    logic        m_pslverr;
    logic        irq = 1'b0;
    logic        busy;

`ifdef SPI_CMD_SEQ_IRQ_EN
    localparam logic [31:0] IE_BIT = 32'h0000_1000;
`else
    localparam logic [31:0] IE_BIT = 32'h0000_0000;
`endif

    spi_cmd_seq #(
        .DIV_VAL(16'h0001), .SS_VAL(8'h01), .MODE(4'b1010), .TIMEOUT(16'd20)
    ) dut (
        .PCLK(PCLK), .PRESETN(PRESETN),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_data(cmd_data), .cmd_len(cmd_len),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .m_paddr(m_paddr), .m_pwdata(m_pwdata),
        .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
        .m_prdata(m_prdata), .m_pready(m_pready), .m_pslverr(m_pslverr),
        .irq(irq), .busy(busy)
    );

    always #5 PCLK = ~PCLK;

    int n_vec = 0;
    int n_err = 0;
    logic [36:0] exp_wr[$];
    logic [32:0] exp_rsp[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- SPI core model (loopback, 1-cycle registered PREADY)
    logic [31:0] tx0 = 32'd0, rx0 = 32'd0, ctrl_reg = 32'd0;
    logic [15:0] go_left = 16'd0;
    int          irq_t = 0;
    logic        hang = 1'b0, inj_en = 1'b0;
    logic [4:0]  inj_addr = 5'd0;
    wire         acc = m_psel & m_penable & m_pready;

    assign m_prdata  = (m_paddr == 5'h10) ? {ctrl_reg[31:9], (go_left != 16'd0), ctrl_reg[7:0]} :
                       (m_paddr == 5'h00) ? rx0 : 32'd0;
    assign m_pslverr = inj_en & acc & m_pwrite & (m_paddr == inj_addr);

    always @(posedge PCLK) begin
        if (!PRESETN) begin
            m_pready <= 1'b0;
            irq      <= 1'b0;
            irq_t    <= 0;
        end else begin
            m_pready <= m_psel & m_penable & !m_pready;
            if (irq_t > 0) begin
                irq_t <= irq_t - 1;
                if (irq_t == 1) irq <= 1'b1;
            end
            if (acc) begin
                if (m_pwrite) begin
                    case (m_paddr)
                        5'h00: tx0 <= m_pwdata;
                        5'h10: begin
                            ctrl_reg <= m_pwdata;
                            rx0      <= tx0;
                            go_left  <= hang ? 16'hFFFF : 16'd1;
                            irq_t    <= hang ? 0 : 3;
                        end
                        default: ;
                    endcase
                end else begin
                    if (m_paddr == 5'h10 && go_left != 16'd0 && !hang) go_left <= go_left - 16'd1;
                    if (m_paddr == 5'h00) irq <= 1'b0;
                end
            end
        end
    end

    // ---------------- monitors
    always @(negedge PCLK) begin
        if (PRESETN && acc && m_pwrite) begin
            if (exp_wr.size() == 0) begin
                check("apb_wr_unexpected_addr", {27'd0, m_paddr}, 32'hFFFF_FFFF);
            end else begin
                logic [36:0] e;
                e = exp_wr.pop_front();
                check("apb_wr_addr", {27'd0, m_paddr}, {27'd0, e[36:32]});
                check("apb_wr_data", m_pwdata, e[31:0]);
            end
        end
    end

    always @(negedge PCLK) begin
        if (PRESETN && rsp_valid && rsp_ready) begin
            if (exp_rsp.size() == 0) begin
                check("rsp_unexpected", rsp_data, 32'hFFFF_FFFF);
            end else begin
                logic [32:0] e;
                e = exp_rsp.pop_front();
                check("rsp_data", rsp_data, e[31:0]);
                check("rsp_err", {31'd0, rsp_err}, {31'd0, e[32]});
            end
        end
    end

    // ---------------- stimulus helpers
    task automatic push_wr(input logic [4:0] a, input logic [31:0] d);
        exp_wr.push_back({a, d});
    endtask

    task automatic push_rsp(input logic e, input logic [31:0] d);
        exp_rsp.push_back({e, d});
    endtask

    task automatic send_cmd(input logic [31:0] d, input logic [4:0] l);
        bit ok;
        ok = 1'b0;
        @(posedge PCLK); #1;
        cmd_data = d; cmd_len = l; cmd_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge PCLK);
            if (cmd_ready) begin ok = 1'b1; break; end
        end
        if (ok) begin @(posedge PCLK); #1; end
        cmd_valid = 1'b0;
        check("cmd_accept", {31'd0, ok}, 32'd1);
    endtask

    task automatic drain(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge PCLK); #1;
            if (exp_rsp.size() == 0 && exp_wr.size() == 0) begin ok = 1'b1; break; end
        end
        check(name, {31'd0, ok}, 32'd1);
    endtask

    task automatic check_zero(input string name);
        check({name, "_psel"},      {31'd0, m_psel},    32'd0);
        check({name, "_penable"},   {31'd0, m_penable}, 32'd0);
        check({name, "_pwrite"},    {31'd0, m_pwrite},  32'd0);
        check({name, "_paddr"},     {27'd0, m_paddr},   32'd0);
        check({name, "_pwdata"},    m_pwdata,           32'd0);
        check({name, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd0);
        check({name, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        check({name, "_rsp_data"},  rsp_data,           32'd0);
        check({name, "_rsp_err"},   {31'd0, rsp_err},   32'd0);
        check({name, "_busy"},      {31'd0, busy},      32'd0);
    endtask

    // Directed transfer: TX word, bit count, CTRL value and masked RX word.
    task automatic xfer(input string name, input logic [31:0] d, input logic [4:0] l,
                        input logic [31:0] ctrl, input logic [31:0] rx);
        push_wr(5'h00, d);
        push_wr(5'h10, ctrl | IE_BIT);
        push_rsp(1'b0, rx);
        send_cmd(d, l);
        drain(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        bit seen;

        // reset state and INIT sequence
        repeat (3) @(negedge PCLK);
        check_zero("rst");
        push_wr(5'h14, 32'h0000_0001);
        push_wr(5'h18, 32'h0000_0001);
        PRESETN = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge PCLK);
            check("init_cmd_ready", {31'd0, cmd_ready}, (k == 7) ? 32'd1 : 32'd0);
            check("init_busy", {31'd0, busy}, (k == 7) ? 32'd0 : 32'd1);
        end
        drain("init_writes");

        // loopback transfers across bit counts
        xfer("cmd_a5_len8",   32'h0000_00A5, 5'd8,  32'h0000_2508, 32'h0000_00A5);
        xfer("cmd_len0_32",   32'hDEAD_BEEF, 5'd0,  32'h0000_2520, 32'hDEAD_BEEF);
        xfer("cmd_len5",      32'hFFFF_FFFF, 5'd5,  32'h0000_2505, 32'h0000_001F);
        xfer("cmd_len31",     32'hFFFF_FFFF, 5'd31, 32'h0000_251F, 32'h7FFF_FFFF);

        // response back-pressure
        rsp_ready = 1'b0;
        push_wr(5'h00, 32'h1234_563C);
        push_wr(5'h10, 32'h0000_2508 | IE_BIT);
        push_rsp(1'b0, 32'h0000_003C);
        send_cmd(32'h1234_563C, 5'd8);
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge PCLK);
            if (rsp_valid) begin seen = 1'b1; break; end
        end
        check("hold_rsp_seen", {31'd0, seen}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            check("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check("hold_rsp_data", rsp_data, 32'h0000_003C);
            check("hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            @(negedge PCLK);
        end
        @(posedge PCLK); #1;
        rsp_ready = 1'b1;
        @(negedge PCLK);
        check("hs_cmd_ready_before", {31'd0, cmd_ready}, 32'd0);
        @(negedge PCLK);
        check("hs_cmd_ready_after", {31'd0, cmd_ready}, 32'd1);
        check("hs_rsp_valid_after", {31'd0, rsp_valid}, 32'd0);
        drain("hold_drain");

        // slave error on the CTRL write
        inj_en = 1'b1; inj_addr = 5'h10;
        push_wr(5'h00, 32'h0000_0055);
        push_wr(5'h10, 32'h0000_2508 | IE_BIT);
        push_rsp(1'b1, 32'h0000_0000);
        send_cmd(32'h0000_0055, 5'd8);
        drain("pslverr_drain");
        inj_en = 1'b0;

        // timeout: core never finishes
        hang = 1'b1;
        push_wr(5'h00, 32'h0000_0077);
        push_wr(5'h10, 32'h0000_2508 | IE_BIT);
        push_rsp(1'b1, 32'h0000_0000);
        send_cmd(32'h0000_0077, 5'd8);
        n = 99;
        for (int i = 0; i < 40; i++) begin
            @(negedge PCLK);
            if (rsp_valid) begin n = i; break; end
        end
        check("timeout_latency_le21", {31'd0, (n <= 21)}, 32'd1);
        drain("timeout_drain");

        // reset pulsed while waiting for the core
        push_wr(5'h00, 32'h0000_0099);
        push_wr(5'h10, 32'h0000_2508 | IE_BIT);
        send_cmd(32'h0000_0099, 5'd8);
        repeat (8) @(negedge PCLK);
        #2 PRESETN = 1'b0;
        #1 check_zero("rst_mid");
        check("rst_mid_wr_done", exp_wr.size(), 32'd0);
        hang = 1'b0;
        push_wr(5'h14, 32'h0000_0001);
        push_wr(5'h18, 32'h0000_0001);
        @(negedge PCLK);
        PRESETN = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge PCLK);
            if (cmd_ready) begin seen = 1'b1; break; end
        end
        check("rst_mid_reinit", {31'd0, seen}, 32'd1);
        drain("rst_mid_drain");

        xfer("cmd_after_rst", 32'h1234_5678, 5'd16, 32'h0000_2510, 32'h0000_5678);

        repeat (5) @(negedge PCLK);
        check("final_rsp_queue", exp_rsp.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
